padring_cfg_ctrl: RTL and testbench
===================================

Name: padring_cfg_ctrl

Overview:
- Owns the per-pad configuration buses of the four-sided soft padring (no/so/ea/we, NGPIO pads per side).
- Serialises configuration writes from a core-side request port. Each write runs a glitch-safe isolate -> apply -> settle sequence on the target pad.
- Between asic_core and the padring: passes core ie/oen through to the pads and masks them only for the pad being reconfigured.

Parameters:
- NGPIO, 9, GPIO pads per side; flat pad index = side*NGPIO + pad.
- CW, 8, config bits per pad.
- SETTLE, 4, cycles in isolate and in settle phases; legal range 1..255.
- CFG_RST, 0, CW-bit reset value of every pad config.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- req_valid  in  1  config write request
- req_ready  out  1  request accepted when valid&ready
- req_side  in  2  0=no, 1=ea, 2=so, 3=we
- req_pad  in  4  pad index within side
- req_cfg  in  CW  new config value
- done  out  1  one-cycle pulse: write sequence complete
- err  out  1  one-cycle pulse: rejected request (pad index out of range)
- core_ie  in  4*NGPIO  input enables from core, flat index
- core_oen  in  4*NGPIO  output enables (bar) from core
- pad_ie  out  4*NGPIO  input enables to padring
- pad_oen  out  4*NGPIO  output enables (bar) to padring
- no_cfg, ea_cfg, so_cfg, we_cfg  out  NGPIO*CW each  per-side config buses; pad p occupies bits [p*CW +: CW]

Behaviour:
- Reset (nreset low, asynchronous):
  - All cfg registers = CFG_RST.
  - iso_mask = 0; state = IDLE; done = 0; err = 0.
  - req_ready = 1 (IDLE).
  - Reset mid-sequence abandons the write: the target keeps CFG_RST and its mask clears immediately.
- Pass-through is combinational, zero latency:
  - pad_ie = core_ie & ~iso_mask.
  - pad_oen = core_oen | iso_mask.
  - Non-target pads track core inputs every cycle, including during a sequence.
- req_ready = (state == IDLE). Only one write is in flight; there is no queue.
- Accept at cycle T with valid index (req_pad < NGPIO):
  - Latch idx and cfg.
  - iso_mask[idx] <= 1, visible T+1. state <= ISO; cnt <= SETTLE-1.
- ISO state, cycles T+1..T+SETTLE:
  - cnt decrements each cycle.
  - When cnt == 0, go to APPLY.
- APPLY state, cycle T+SETTLE+1:
  - cfg[idx] <= latched cfg, visible T+SETTLE+2.
  - cnt <= SETTLE-1; go to SETL.
- SETL state, cycles T+SETTLE+2..T+2*SETTLE+1:
  - cnt decrements each cycle.
  - On cnt == 0: iso_mask[idx] <= 0 and go to DONE.
- DONE state, cycle T+2*SETTLE+2:
  - done = 1; req_ready = 0; iso_mask already clear.
  - Next cycle: IDLE, req_ready = 1.
- Total occupancy is 2*SETTLE+2 cycles after accept. With SETTLE=4, back-to-back requests are accepted every 11 cycles.
- Invalid index (req_pad >= NGPIO):
  - Request is accepted (handshake completes).
  - err = 1 at T+1 for one cycle.
  - No state, mask or cfg change; req_ready stays 1.
- Rewriting a pad with its current value still runs the full sequence and pulses done.
- done and err are registered; they never assert in the same cycle.
- req_* are ignored while req_ready = 0. Inputs are sampled only on the accepting edge; later changes do not affect the write in progress.
- Only cfg[idx] changes, and only at the APPLY edge. All other pad configs hold.

Test Plan:
- Reset then idle, SETTLE=4, CFG_RST=0: all *_cfg = 0, req_ready = 1, done = err = 0. With core_ie = all 1s and core_oen = all 0s, pad_ie = all 1s and pad_oen = all 0s.
- Write side=2, pad=3, cfg=0xA5 accepted at cycle 0:
  - pad_ie[21] = 0 and pad_oen[21] = 1 during cycles 1..9.
  - so_cfg[31:24] = 0xA5 from cycle 6.
  - done pulse at cycle 10; req_ready = 1 at cycle 11.
  - Toggling core_ie[0] mid-sequence appears on pad_ie[0] in the same cycle.
- Request with side=0, pad=9 -> err = 1 at cycle 1 only; all cfg buses unchanged; req_ready held high. A valid request accepted at cycle 2 then proceeds normally.
- req_valid held high across two requests (we pad 8 = 0x3C, then ea pad 0 = 0xFF): second accepted at cycle 11 after the first's done at cycle 10; req_ready low on cycles 1..10. Afterwards we_cfg[71:64] = 0x3C and ea_cfg[7:0] = 0xFF.
- nreset asserted at cycle 7 of a write to no pad 1 with cfg 0x55:
  - Immediately no_cfg[15:8] = 0 (CFG_RST), iso_mask clears, no done pulse.
  - After release, req_ready = 1 and a new write completes normally.

Source files
------------

// File: rtl/padring_cfg_ctrl.sv
//------------------------------------------------------------------------------
// padring_cfg_ctrl
//
// Owns the per-pad configuration registers of the four-sided soft padring and
// serialises core-side configuration writes. Each accepted write isolates the
// target pad, applies the new config, lets it settle, then releases the pad.
// Core ie/oen pass straight through to the pads. Only the pad currently being
// reconfigured is masked: its ie is forced low and its oen forced high.
//
// Ports
//   clk, nreset              clock, asynchronous active-low reset
//   req_valid/req_ready      config write handshake (one write in flight)
//   req_side, req_pad        target pad (side 0=no 1=ea 2=so 3=we), pad in side
//   req_cfg                  new config value
//   done                     one-cycle pulse when a write sequence completes
//   err                      one-cycle pulse for a rejected (out-of-range) pad
//   core_ie, core_oen        enables from core, flat index side*NGPIO+pad
//   pad_ie, pad_oen          enables to padring after isolation masking
//   no/ea/so/we_cfg          per-side config buses, pad p at [p*CW +: CW]
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready for a request; req_ready high
// ISO    | target pad isolated, waiting SETTLE cycles before touching config
// APPLY  | one cycle: latched config written into the target register
// SETL   | new config settling for SETTLE cycles, pad still isolated
// DONE   | isolation released, done pulse visible; back to IDLE next cycle
//------------------------------------------------------------------------------
module padring_cfg_ctrl #(
   parameter int            NGPIO   = 9,
   parameter int            CW      = 8,
   parameter int            SETTLE  = 4,
   parameter logic [CW-1:0] CFG_RST = '0
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_side,
   input  logic [3:0]            req_pad,
   input  logic [CW-1:0]         req_cfg,
   output logic                  done,
   output logic                  err,
   input  logic [4*NGPIO-1:0]    core_ie,
   input  logic [4*NGPIO-1:0]    core_oen,
   output logic [4*NGPIO-1:0]    pad_ie,
   output logic [4*NGPIO-1:0]    pad_oen,
   output logic [NGPIO*CW-1:0]   no_cfg,
   output logic [NGPIO*CW-1:0]   ea_cfg,
   output logic [NGPIO*CW-1:0]   so_cfg,
   output logic [NGPIO*CW-1:0]   we_cfg
);

   localparam int        NP        = 4 * NGPIO;
   localparam int        IDXW      = $clog2(NP);
   localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISO   = 3'd1,
      ST_APPLY = 3'd2,
      ST_SETL  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [CW-1:0]     cfg_lat_q, cfg_lat_d;
   logic [NP-1:0]     iso_mask_q, iso_mask_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [CW-1:0]     cfg_q [NP];
   logic [CW-1:0]     cfg_d [NP];

   logic              pad_ok;
   logic [IDXW-1:0]   req_idx;

   assign pad_ok  = (32'(req_pad) < NGPIO);
   assign req_idx = IDXW'(req_side) * IDXW'(NGPIO) + IDXW'(req_pad);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      cfg_lat_d  = cfg_lat_q;
      iso_mask_d = iso_mask_q;
      cfg_d      = cfg_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (pad_ok) begin
                  idx_d               = req_idx;
                  cfg_lat_d           = req_cfg;
                  iso_mask_d[req_idx] = 1'b1;
                  cnt_d               = SETTLE_M1;
                  state_d             = ST_ISO;
               end else begin
                  // Handshake still completes; nothing else moves.
                  err_d = 1'b1;
               end
            end
         end
         ST_ISO: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_APPLY;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_APPLY: begin
            cfg_d[idx_q] = cfg_lat_q;
            cnt_d        = SETTLE_M1;
            state_d      = ST_SETL;
         end
         ST_SETL: begin
            if (cnt_q == 8'd0) begin
               // Release the pad on the same edge the done pulse is raised,
               // so the mask is already clear while done is high.
               iso_mask_d[idx_q] = 1'b0;
               done_d            = 1'b1;
               state_d           = ST_DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         cfg_lat_q  <= CFG_RST;
         iso_mask_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < NP; i++) begin
            cfg_q[i] <= CFG_RST;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         cfg_lat_q  <= cfg_lat_d;
         iso_mask_q <= iso_mask_d;
         done_q     <= done_d;
         err_q      <= err_d;
         for (int i = 0; i < NP; i++) begin
            cfg_q[i] <= cfg_d[i];
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   assign pad_ie    = core_ie & ~iso_mask_q;
   assign pad_oen   = core_oen | iso_mask_q;

   for (genvar p = 0; p < NGPIO; p++) begin : g_bus
      assign no_cfg[p*CW +: CW] = cfg_q[p];
      assign ea_cfg[p*CW +: CW] = cfg_q[NGPIO + p];
      assign so_cfg[p*CW +: CW] = cfg_q[2*NGPIO + p];
      assign we_cfg[p*CW +: CW] = cfg_q[3*NGPIO + p];
   end

endmodule

// File: tb/tb_padring_cfg_ctrl.sv
module tb_padring_cfg_ctrl;

   localparam int NGPIO  = 9;
   localparam int CW     = 8;
   localparam int SETTLE = 4;
   localparam int NP     = 4 * NGPIO;

   logic                clk;
   logic                nreset;
   logic                req_valid;
   logic                req_ready;
   logic [1:0]          req_side;
   logic [3:0]          req_pad;
   logic [CW-1:0]       req_cfg;
   logic                done;
   logic                err;
   logic [NP-1:0]       core_ie;
   logic [NP-1:0]       core_oen;
   logic [NP-1:0]       pad_ie;
   logic [NP-1:0]       pad_oen;
   logic [NGPIO*CW-1:0] no_cfg;
   logic [NGPIO*CW-1:0] ea_cfg;
   logic [NGPIO*CW-1:0] so_cfg;
   logic [NGPIO*CW-1:0] we_cfg;

   padring_cfg_ctrl #(
      .NGPIO(NGPIO), .CW(CW), .SETTLE(SETTLE), .CFG_RST(8'h00)
   ) dut (
      .clk(clk), .nreset(nreset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_side(req_side), .req_pad(req_pad), .req_cfg(req_cfg),
      .done(done), .err(err),
      .core_ie(core_ie), .core_oen(core_oen),
      .pad_ie(pad_ie), .pad_oen(pad_oen),
      .no_cfg(no_cfg), .ea_cfg(ea_cfg), .so_cfg(so_cfg), .we_cfg(we_cfg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after posedge k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      int         k_exp;
      int         idx;
      logic [7:0] cfg;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference model: architectural config per flat pad plus the write in flight.
   logic [7:0]  model_cfg [NP];
   bit          cur_valid = 0;
   int          cur_idx   = 0;
   int          cur_edge  = 0;
   logic [7:0]  cur_cfg   = '0;
   bit          rand_core = 0;

   function automatic void chk(string nm, logic [287:0] act, logic [287:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endfunction

   function automatic logic [287:0] all_cfg();
      return {we_cfg, so_cfg, ea_cfg, no_cfg};
   endfunction

   // Monitor: compares every cycle against the model, pops scoreboard on pulses.
   task automatic monitor_step();
      logic [NP-1:0] m;
      logic [287:0]  ecfg;
      logic          exp_ready;
      int            r;
      exp_t          e;
      m = '0;
      exp_ready = 1'b1;
      if (cur_valid) begin
         r = cyc - cur_edge + 1;
         if (r >= SETTLE + 2) model_cfg[cur_idx] = cur_cfg;
         if (r >= 1 && r <= 2*SETTLE + 1) m[cur_idx] = 1'b1;
         if (r >= 1 && r <= 2*SETTLE + 2) exp_ready = 1'b0;
      end
      ecfg = '0;
      for (int i = 0; i < NP; i++) ecfg[i*8 +: 8] = model_cfg[i];
      chk("pad_ie", 288'(pad_ie), 288'(core_ie & ~m));
      chk("pad_oen", 288'(pad_oen), 288'(core_oen | m));
      chk("req_ready", 288'(req_ready), 288'(exp_ready));
      chk("cfg_buses", all_cfg(), ecfg);
      if (done || err) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse", 288'({done, err}), 288'(2'b00));
         end else begin
            e = sb_q.pop_front();
            chk("pulse_kind", 288'({done, err}), 288'(e.is_err ? 2'b01 : 2'b10));
            chk("pulse_edge", 288'(cyc), 288'(e.k_exp));
            if (!e.is_err) chk("done_cfg", 288'(all_cfg() >> (e.idx*8)) & 288'hFF, 288'(e.cfg));
         end
      end else if (sb_q.size() != 0 && sb_q[0].k_exp < cyc) begin
         e = sb_q.pop_front();
         chk("pulse_missing", 288'({done, err}), 288'(e.is_err ? 2'b01 : 2'b10));
      end
   endtask

   always @(negedge clk) begin
      #2;
      monitor_step();
   end

   task automatic tick();
      @(negedge clk);
      if (rand_core) begin
         core_ie  = 36'({$urandom(), $urandom()});
         core_oen = 36'({$urandom(), $urandom()});
      end
   endtask

   // Presents a request (call right after tick) and returns just before the
   // accepting edge; inputs stay asserted so the caller decides what follows.
   task automatic issue(input logic [1:0] s, input logic [3:0] p, input logic [7:0] c);
      int   n;
      int   a;
      exp_t e;
      req_valid = 1'b1;
      req_side  = s;
      req_pad   = p;
      req_cfg   = c;
      #1;
      n = 0;
      while (!req_ready && n < 100) begin
         tick();
         #1;
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 288'(req_ready), 288'(1'b1));
         return;
      end
      a = cyc + 1;
      if (int'(p) < NGPIO) begin
         cur_valid = 1;
         cur_idx   = int'(s) * NGPIO + int'(p);
         cur_edge  = a;
         cur_cfg   = c;
         e.is_err  = 0;
         e.k_exp   = a + 2*SETTLE + 1;
         e.idx     = cur_idx;
         e.cfg     = c;
      end else begin
         e.is_err  = 1;
         e.k_exp   = a;
         e.idx     = 0;
         e.cfg     = '0;
      end
      sb_q.push_back(e);
   endtask

   task automatic model_reset();
      cur_valid = 0;
      for (int i = 0; i < NP; i++) model_cfg[i] = '0;
      sb_q.delete();
   endtask

   initial begin
      logic [1:0] s;
      logic [3:0] p;
      logic [7:0] c;
      int         n;

      model_reset();
      nreset    = 1'b0;
      req_valid = 1'b0;
      req_side  = '0;
      req_pad   = '0;
      req_cfg   = '0;
      core_ie   = '1;
      core_oen  = '0;
      repeat (3) tick();
      nreset = 1'b1;
      tick();
      #1;
      chk("rst_ready", 288'(req_ready), 288'(1'b1));
      chk("rst_done_err", 288'({done, err}), 288'(2'b00));
      chk("rst_cfg", all_cfg(), 288'(0));
      chk("rst_pad_ie", 288'(pad_ie), 288'({NP{1'b1}}));
      chk("rst_pad_oen", 288'(pad_oen), 288'(0));

      // so pad 3 (flat 21) = 0xA5, with a core_ie[0] toggle mid-sequence.
      issue(2'd2, 4'd3, 8'hA5);
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      core_ie[0] = ~core_ie[0];
      #1;
      chk("ie0_passthru", 288'(pad_ie[0]), 288'(core_ie[0]));
      chk("pad21_isolated", 288'({pad_ie[21], pad_oen[21]}), 288'(2'b01));
      repeat (8) tick();
      chk("so3_cfg", 288'(so_cfg[31:24]), 288'(8'hA5));

      // Out-of-range pad, then a valid write two cycles later.
      issue(2'd0, 4'd9, 8'h77);
      tick();
      req_valid = 1'b0;
      tick();
      issue(2'd1, 4'd4, 8'h5A);
      tick();
      req_valid = 1'b0;
      repeat (12) tick();

      // Back-to-back with req_valid held high.
      issue(2'd3, 4'd8, 8'h3C);
      tick();
      issue(2'd1, 4'd0, 8'hFF);
      tick();
      req_valid = 1'b0;
      repeat (12) tick();
      chk("we8_cfg", 288'(we_cfg[71:64]), 288'(8'h3C));
      chk("ea0_cfg", 288'(ea_cfg[7:0]), 288'(8'hFF));

      // Reset during cycle 7 of a write to no pad 1.
      issue(2'd0, 4'd1, 8'h55);
      tick();
      req_valid = 1'b0;
      repeat (6) tick();
      #3;
      nreset = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_cfg", 288'(no_cfg[15:8]), 288'(8'h00));
      chk("rst_mid_mask", 288'({pad_ie[1], pad_oen[1]}), 288'({core_ie[1], core_oen[1]}));
      repeat (2) tick();
      nreset = 1'b1;
      tick();
      issue(2'd0, 4'd2, 8'hC3);
      tick();
      req_valid = 1'b0;
      repeat (12) tick();

      // Randomised phase with random core enables and some out-of-range pads.
      rand_core = 1;
      for (int k = 0; k < 40; k++) begin
         s = 2'($urandom_range(0, 3));
         p = 4'($urandom_range(0, 11));
         c = 8'($urandom_range(0, 255));
         if (int'(p) < NGPIO && $urandom_range(0, 3) == 0)
            c = model_cfg[int'(s) * NGPIO + int'(p)];
         issue(s, p, c);
         tick();
         n = $urandom_range(0, 2);
         if (n != 0) begin
            req_valid = 1'b0;
            repeat (n) tick();
         end
      end
      req_valid = 1'b0;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      chk("scoreboard_drained", 288'(sb_q.size()), 288'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
